// File: rtl/enigma_stream_pkg.sv
// enigma_stream_pkg: shared types and sizes for the enigma stream driver
package enigma_stream_pkg;
  localparam int BYTE_W = 8;
  localparam int DEFAULT_DEPTH = 16;
  typedef enum logic [2:0] {IDLE, SET, WAIT, RUN, DRAIN} state_t;
endpackage

// File: rtl/enigma_stream_driver_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with full/empty/count
module sync_fifo import enigma_stream_pkg::*; #(
  parameter int W = BYTE_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rp_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_comb begin
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/enigma_stream_driver.sv
// enigma_stream_driver: buffers host bytes, feeds the enigma core under a credit rule, collects results in order
module enigma_stream_driver import enigma_stream_pkg::*; #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int SET_GAP = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              dec_in,
  input  logic              wr_valid,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [BYTE_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              core_set,
  output logic              core_en,
  output logic              core_valid,
  output logic [BYTE_W-1:0] core_din,
  output logic              core_dec,
  input  logic [BYTE_W-1:0] core_dout,
  input  logic              core_done,
  output logic              busy,
  output logic              err
);
  localparam int AW = $clog2(DEPTH);
  state_t state_q, state_d;
  logic stop_pend_q, stop_pend_d;
  logic [3:0] gap_q, gap_d;
  logic [AW:0] outstanding_q, outstanding_d;
  logic core_valid_q, core_valid_d, core_dec_q, core_dec_d, err_q, err_d;
  logic [BYTE_W-1:0] core_din_q, core_din_d, in_head;
  logic in_full, in_empty, out_full, out_empty;
  logic [AW:0] in_count, out_count;
  logic [AW+1:0] credit_sum;
  logic wr_fire, gap_last, issue_ok, credit, issue, in_push, in_pop, done_ok, out_pop;
  assign wr_ready = !in_full && state_q != DRAIN;
  assign wr_fire = wr_valid && wr_ready;
  assign gap_last = gap_q == 4'(SET_GAP - 1);
  // the last WAIT cycle may issue so the first byte lands exactly SET_GAP idle cycles after core_set
  assign issue_ok = state_q == RUN || state_q == DRAIN || (state_q == WAIT && gap_last);
  assign credit_sum = {1'b0, outstanding_q} + {1'b0, out_count};
  assign credit = credit_sum < (AW+2)'(DEPTH);
  assign issue = issue_ok && credit && (!in_empty || wr_fire);
  // an empty input FIFO is bypassed so a fresh write reaches the core on the next cycle
  assign in_push = wr_fire && !(issue && in_empty);
  assign in_pop = issue && !in_empty;
  assign done_ok = core_done && outstanding_q != '0;
  assign out_pop = !out_empty && rd_ready;
  assign rd_valid = !out_empty;
  assign core_set = state_q == SET;
  assign core_en = state_q != IDLE;
  assign busy = state_q != IDLE;
  assign core_valid = core_valid_q;
  assign core_din = core_din_q;
  assign core_dec = core_dec_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    stop_pend_d = stop_pend_q;
    gap_d = '0;
    core_dec_d = core_dec_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SET;
        core_dec_d = dec_in;
        stop_pend_d = 1'b0;
      end
      SET: begin
        state_d = WAIT;
        stop_pend_d = stop_pend_q || stop;
      end
      WAIT: begin
        stop_pend_d = stop_pend_q || stop;
        gap_d = gap_last ? '0 : gap_q + 4'd1;
        state_d = gap_last ? RUN : WAIT;
      end
      RUN: if (stop || stop_pend_q) begin
        state_d = DRAIN;
        stop_pend_d = 1'b0;
      end
      DRAIN: state_d = (in_count == '0 && outstanding_q == '0) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    core_valid_d = issue;
    core_din_d = issue ? (in_empty ? wr_data : in_head) : core_din_q;
    outstanding_d = outstanding_q + (AW+1)'(issue) - (AW+1)'(done_ok);
    err_d = err_q || (core_done && (outstanding_q == '0 || out_full));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      stop_pend_q <= 1'b0;
      gap_q <= '0;
      outstanding_q <= '0;
      core_valid_q <= 1'b0;
      core_din_q <= '0;
      core_dec_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_pend_q <= stop_pend_d;
      gap_q <= gap_d;
      outstanding_q <= outstanding_d;
      core_valid_q <= core_valid_d;
      core_din_q <= core_din_d;
      core_dec_q <= core_dec_d;
      err_q <= err_d;
    end
  end
  sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .reset_n(reset_n), .push(in_push), .din(wr_data), .pop(in_pop),
    .dout(in_head), .full(in_full), .empty(in_empty), .count(in_count)
  );
  sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .reset_n(reset_n), .push(done_ok), .din(core_dout), .pop(out_pop),
    .dout(rd_data), .full(out_full), .empty(out_empty), .count(out_count)
  );
endmodule

// File: tb/tb_enigma_stream_driver.sv
// tb_enigma_stream_driver: directed checks of the stream driver against a latency-7 XOR-0x20 core model
module tb_enigma_stream_driver;
  typedef struct packed { logic [7:0] din; logic [7:0] exp; } vec_t;
  logic clk = 0, reset_n = 0, start = 0, stop = 0, dec_in = 0, wr_valid = 0, rd_ready = 0, inj = 0;
  logic [7:0] wr_data = 0, inj_data = 0;
  logic wr_ready, rd_valid, core_set, core_en, core_valid, core_dec, core_done, busy, err;
  logic [7:0] rd_data, core_din, core_dout;
  logic [6:0] pv = '0;
  logic [7:0] pd [7];
  int n_cmp = 0, n_bad = 0, set_cnt = 0, issued = 0, popped = 0, max_inflight = 0;
  int w_i, w_g, r_j, r_g;
  logic saw_full = 0;
  always #5 clk = ~clk;
  enigma_stream_driver #(.DEPTH(16), .SET_GAP(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dec_in(dec_in),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .core_set(core_set), .core_en(core_en), .core_valid(core_valid), .core_din(core_din),
    .core_dec(core_dec), .core_dout(core_dout), .core_done(core_done), .busy(busy), .err(err)
  );
  always @(posedge clk) begin
    pv <= {pv[5:0], core_valid};
    pd[0] <= core_din ^ 8'h20;
    for (int i = 1; i < 7; i++) pd[i] <= pd[i-1];
    if (core_set) set_cnt <= set_cnt + 1;
    issued <= issued + int'(core_valid);
    popped <= popped + int'(rd_valid && rd_ready);
    if (issued - popped > max_inflight) max_inflight <= issued - popped;
  end
  assign core_done = pv[6] | inj;
  assign core_dout = inj ? inj_data : pd[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic pop_check(input string nm, input logic [7:0] exp);
    int g = 0;
    @(negedge clk);
    while (!rd_valid && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk(nm, 32'({rd_valid, rd_data}), 32'({1'b1, exp}));
    rd_ready = 1;
    cyc();
    rd_ready = 0;
  endtask
  task automatic wait_idle(input string nm);
    int g = 0;
    @(negedge clk);
    while (busy && g < 60) begin
      cyc();
      @(negedge clk);
      g++;
    end
    chk(nm, 32'(busy), 0);
    cyc();
  endtask
  initial begin
    vec_t tv [8];
    int g, lat, s0;
    logic rdv_seen;
    tv = '{'{8'h00, 8'h20}, '{8'hff, 8'hdf}, '{8'h20, 8'h00}, '{8'h41, 8'h61},
           '{8'h7a, 8'h5a}, '{8'h80, 8'ha0}, '{8'h5f, 8'h7f}, '{8'hc3, 8'he3}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", 32'({wr_ready, rd_valid, core_set, core_en, core_valid, core_dec, busy, err}), 32'h80);
    chk("reset_din", 32'(core_din), 0);
    reset_n = 1;
    cyc(); cyc();
    wr_valid = 1; wr_data = 8'h10; cyc();
    wr_valid = 0; start = 1; dec_in = 1; cyc();
    start = 0; dec_in = 0;
    @(negedge clk); chk("set_pulse", 32'({core_set, core_en, core_dec, busy}), 32'hf);
    cyc(); @(negedge clk); chk("set_once", 32'({core_set, core_valid}), 0);
    cyc(); @(negedge clk); chk("gap_idle", 32'(core_valid), 0);
    cyc(); @(negedge clk); chk("first_valid", 32'({core_valid, core_din}), 32'({1'b1, 8'h10}));
    cyc(); pop_check("first_result", 8'h30);
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_data = tv[i].din;
      @(negedge clk); chk("tv_wr_ready", 32'(wr_ready), 1);
      cyc(); wr_valid = 0;
      @(negedge clk); chk("tv_issue", 32'({core_valid, core_din}), 32'({1'b1, tv[i].din}));
      lat = 0;
      while (!rd_valid && lat < 20) begin
        cyc(); @(negedge clk); lat++;
      end
      chk("tv_latency", 32'(lat), 8);
      chk("tv_result", 32'({rd_valid, rd_data}), 32'({1'b1, tv[i].exp}));
      rd_ready = 1; cyc(); rd_ready = 0;
    end
    stop = 1; cyc(); stop = 0;
    wait_idle("s1_idle");
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = 8'(8'h41 + i); cyc();
    end
    wr_valid = 0; start = 1; cyc();
    start = 0; stop = 1; cyc(); stop = 0;
    g = 0;
    @(negedge clk);
    while (!core_valid && g < 20) begin
      cyc(); @(negedge clk); g++;
    end
    chk("pf_din0", 32'({core_valid, core_din, core_dec}), 32'({1'b1, 8'h41, 1'b0}));
    cyc(); @(negedge clk); chk("pf_din1", 32'({core_valid, core_din}), 32'({1'b1, 8'h42}));
    cyc(); @(negedge clk); chk("pf_din2", 32'({core_valid, core_din}), 32'({1'b1, 8'h43}));
    g = 0;
    while (busy && g < 30) begin
      cyc(); @(negedge clk); g++;
    end
    chk("pf_busy_drop", 32'(g), 9);
    cyc();
    pop_check("pf_rd0", 8'h61);
    pop_check("pf_rd1", 8'h62);
    pop_check("pf_rd2", 8'h63);
    @(negedge clk); chk("pf_drained", 32'(rd_valid), 0);
    cyc();
    wr_valid = 1; wr_data = 8'h01; cyc();
    wr_data = 8'h02; cyc();
    wr_valid = 0; s0 = set_cnt; start = 1; cyc();
    start = 0; cyc();
    stop = 1; start = 1; cyc();
    stop = 0; start = 0;
    wait_idle("sw_idle");
    chk("sw_one_set", 32'(set_cnt - s0), 1);
    pop_check("sw_rd0", 8'h21);
    pop_check("sw_rd1", 8'h22);
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    saw_full = 0;
    fork
      begin
        w_i = 0; w_g = 0;
        while (w_i < 40 && w_g < 1500) begin
          wr_valid = 1; wr_data = 8'(8'ha0 + w_i);
          @(negedge clk);
          if (wr_ready) w_i++;
          else saw_full = 1;
          cyc(); w_g++;
        end
        wr_valid = 0;
      end
      begin
        r_g = 0;
        while (!saw_full && r_g < 600) begin
          @(negedge clk); r_g++;
        end
        r_j = 0;
        while (r_j < 40 && r_g < 2000) begin
          @(negedge clk);
          rd_ready = 1;
          if (rd_valid) begin
            chk("bp_order", 32'(rd_data), 32'(8'(8'ha0 + r_j) ^ 8'h20));
            r_j++;
          end
          r_g++;
        end
        cyc(); rd_ready = 0;
      end
    join
    chk("bp_count", 32'(r_j), 40);
    chk("bp_backpressure", 32'(saw_full), 1);
    chk("bp_credit", 32'(max_inflight), 16);
    chk("bp_err", 32'(err), 0);
    stop = 1; cyc(); stop = 0;
    wait_idle("bp_idle");
    @(negedge clk); chk("inj_pre", 32'({err, rd_valid}), 0);
    cyc();
    inj = 1; inj_data = 8'h55; cyc();
    inj = 0;
    @(negedge clk); chk("inj_err", 32'({err, rd_valid}), 32'h2);
    repeat (5) cyc();
    @(negedge clk); chk("inj_sticky", 32'({err, rd_valid}), 32'h2);
    cyc();
    dec_in = 1; start = 1; cyc();
    start = 0; dec_in = 0;
    repeat (4) cyc();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_data = 8'(8'h30 + i); cyc();
    end
    wr_valid = 0;
    @(negedge clk); chk("rr_inflight", 32'({core_valid, core_dec, err}), 32'h7);
    cyc();
    #2 reset_n = 0;
    #1;
    chk("rr_reset_flags", 32'({wr_ready, rd_valid, core_set, core_en, core_valid, core_dec, busy, err}), 32'h80);
    chk("rr_reset_din", 32'(core_din), 0);
    @(negedge clk); reset_n = 1;
    rdv_seen = 0;
    repeat (12) begin
      cyc(); @(negedge clk);
      if (rd_valid) rdv_seen = 1;
    end
    chk("rr_late_err", 32'(err), 1);
    chk("rr_no_rd", 32'({rdv_seen, busy}), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
